pipe_shift_rotate: RTL
======================

Name: pipe_shift_rotate

Overview:
- Parametrised, pipelined shift/rotate unit for the execute stage. Successor to the single-cycle rotate-right / arithmetic-shift helpers.
- Supports SLL, SRL, SRA, ROR and ROL at any power-of-two width.
- Splits the log2(WIDTH) barrel levels across STAGES register stages, with valid/ready handshakes on both sides.
- Produces the result, a carry-out, a zero flag and a passed-through tag, so the unit can run as a multi-cycle functional unit.

Parameters:
- WIDTH, 32, operand/result width; power of two, 4..64.
- STAGES, 2, pipeline register stages; 1..clog2(WIDTH).
- TAG_W, 5, width of the sideband tag carried with each operation (e.g. destination register).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit accepts a request this cycle.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL; 101..111 reserved.
- in_a  in  WIDTH  operand.
- in_s  in  clog2(WIDTH)  shift/rotate amount, unsigned.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_b  out  WIDTH  result.
- out_c  out  1  carry-out.
- out_z  out  1  high when out_b == 0.
- out_bad  out  1  op was reserved.
- out_tag  out  TAG_W  tag of the returned op.

Behaviour:
- Reset (asynchronous, immediate):
  - every stage valid bit clears;
  - out_valid=0, out_b=0, out_c=0, out_z=0, out_bad=0, out_tag=0;
  - in_ready=1 after reset.
  - Operations in flight when rst asserts are discarded and never reported.
- Transfers:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Levels:
  - L = clog2(WIDTH); level k shifts/rotates by 2^k when in_s[k]=1.
  - LPS = ceil(L/STAGES) levels per stage. Stage j performs levels j*LPS .. min((j+1)*LPS, L)-1, then registers the result.
  - The last stage register drives the outputs.
- Fill behaviour:
  - Stage j (j<STAGES-1) loads when it is empty or stage j+1 loads this cycle.
  - The last stage loads when it is empty or an output transfer occurs.
  - in_ready = stage 0 load condition. Bubbles collapse.
- Latency and throughput:
  - Unstalled latency is exactly STAGES cycles from the input transfer to out_valid.
  - Throughput is one op per cycle when out_ready is held at 1.
- Holding rule: while out_valid=1 and out_ready=0, out_b, out_c, out_z, out_bad and out_tag hold stable. No data is lost or duplicated.
- Arithmetic per op:
  - SLL: zero-fill from the right.
  - SRL: zero-fill from the left.
  - SRA: fill with in_a[WIDTH-1].
  - ROR: out_b = (a>>s)|(a<<(WIDTH-s)).
  - ROL: out_b = (a<<s)|(a>>(WIDTH-s)).
  - s=0: out_b=in_a for every valid op.
- Carry-out is computed from in_a/in_s at input and carried down the pipe:
  - s=0 gives c=0 for all ops.
  - SLL: c=a[WIDTH-s].
  - SRL/SRA: c=a[s-1].
  - ROR: c=out_b[WIDTH-1].
  - ROL: c=out_b[0].
- Reserved op: out_b=in_a, out_c=0, out_bad=1. out_z is computed on out_b as usual.
- Simultaneous events: input and output transfers in the same cycle are legal in every occupancy state, including a full pipe.
- Parameter check: illegal WIDTH or STAGES is a compile-time error.

Test Plan (WIDTH=32, STAGES=2, TAG_W=5):
- Rotate basic: ROR a=0x8000_0001, s=1, tag=3, out_ready=1 -> after 2 cycles out_b=0xC000_0000, out_c=1, out_z=0, out_tag=3. ROL with the same a, s=1 -> 0x0000_0003, out_c=1.
- Shift fill and carry:
  - SRA a=0xF000_0000, s=4 -> 0xFF00_0000, c=0.
  - SRL a=0xF000_0000, s=4 -> 0x0F00_0000.
  - SLL a=0x8000_0001, s=1 -> 0x0000_0002, c=1.
  - SLL a=0x0000_0001, s=31 -> 0x8000_0000, out_z=0.
- Boundaries:
  - every op with s=0 on a=0x1234_5678 -> out_b=0x1234_5678, c=0.
  - SRL a=0x8000_0000, s=31 -> 0x1, c=0.
  - SLL a=0x2, s=31 -> 0, out_z=1, c=1.
  - op=110 -> out_b=a, out_bad=1.
- Backpressure: stream 5 ops back-to-back with out_ready=0 -> in_ready drops after 2 accepted. Then hold out_ready=1 for 1 cycle every 3 -> all 5 results in order, tags 0..4, each stable while stalled.
- Full throughput with simultaneous transfers: 20 random ops with in_valid=out_ready=1 -> one result per cycle, matches the reference model, in_ready never deasserts.
- Reset mid-operation: 2 ops in flight, assert rst for 1 cycle asynchronously -> outputs immediately 0, out_valid=0, no stale result appears afterwards, next op returns in 2 cycles.

Source files
------------

// File: rtl/pipe_shift_rotate.sv
// pipe_shift_rotate: pipelined shift/rotate functional unit.
// The log2(WIDTH) barrel levels are split evenly over STAGES register stages.
// Each stage carries the partially shifted value plus the op, amount, carry
// and tag it belongs to. The last stage register drives the result port.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. in_ready depends only on pipeline occupancy and out_ready.
// It never depends on in_valid. While out_valid is high and out_ready is low,
// every output holds its value.
module pipe_shift_rotate #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_op,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [$clog2(WIDTH)-1:0] in_s,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_b,
    output logic                     out_c,
    output logic                     out_z,
    output logic                     out_bad,
    output logic [TAG_W-1:0]         out_tag
);
    localparam int L    = $clog2(WIDTH);
    localparam int LPS  = (L + STAGES - 1) / STAGES;
    localparam int LAST = STAGES - 1;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROR = 3'b011;
    localparam logic [2:0] OP_ROL = 3'b100;

    // Illegal geometry stops elaboration.
    if (WIDTH < 4 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("pipe_shift_rotate: WIDTH must be a power of two in 4..64");
    end
    if (STAGES < 1 || STAGES > L) begin : g_bad_stages
        $error("pipe_shift_rotate: STAGES must be in 1..clog2(WIDTH)");
    end

    // Apply the barrel levels in [lo, hi) to x. Level k moves by 2^k when s[k] is set.
    // Reserved ops fall through unchanged.
    function automatic logic [WIDTH-1:0] apply_levels(
        input logic [WIDTH-1:0] x,
        input logic [2:0]       op,
        input logic [L-1:0]     s,
        input int               lo,
        input int               hi
    );
        logic [WIDTH-1:0] r;
        r = x;
        for (int k = 0; k < L; k++) begin
            if (k >= lo && k < hi && s[k]) begin
                case (op)
                    OP_SLL:  r = r << (1 << k);
                    OP_SRL:  r = r >> (1 << k);
                    OP_SRA:  r = $signed(r) >>> (1 << k);
                    OP_ROR:  r = (r >> (1 << k)) | (r << (WIDTH - (1 << k)));
                    OP_ROL:  r = (r << (1 << k)) | (r >> (WIDTH - (1 << k)));
                    default: r = r;
                endcase
            end
        end
        return r;
    endfunction

    // Per-stage pipeline registers
    logic             v_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [2:0]       op_q  [STAGES];
    logic [L-1:0]     s_q   [STAGES];
    logic             c_q   [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic             z_q;

    // Per-stage inputs (previous register or the request port) and next values
    logic             src_v   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [2:0]       src_op  [STAGES];
    logic [L-1:0]     src_s   [STAGES];
    logic             src_c   [STAGES];
    logic [TAG_W-1:0] src_tag [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [STAGES-1:0] load;

    // The carry bit is taken from the original operand.
    // For ROR the bit that ends up in the MSB is a[s-1]. For ROL the bit that ends up in the LSB is a[WIDTH-s].
    // So the rotates share their index with the matching shifts.
    logic [L-1:0] s_neg;
    logic [L-1:0] s_m1;
    logic         in_c;

    assign s_neg = ~in_s + L'(1);
    assign s_m1  = in_s - L'(1);

    // Raw carry selection at issue. The s=0 case is suppressed at the output.
    always_comb begin
        in_c = 1'b0;
        case (in_op)
            OP_SLL, OP_ROL:         in_c = in_a[s_neg];
            OP_SRL, OP_SRA, OP_ROR: in_c = in_a[s_m1];
            default:                in_c = 1'b0;
        endcase
    end

    // Wire each stage to its source and to its slice of the barrel levels.
    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        localparam int LO = j * LPS;
        localparam int HI = ((j + 1) * LPS < L) ? (j + 1) * LPS : L;
        if (j == 0) begin : g_src_port
            assign src_v[j]   = in_valid;
            assign src_b[j]   = in_a;
            assign src_op[j]  = in_op;
            assign src_s[j]   = in_s;
            assign src_c[j]   = in_c;
            assign src_tag[j] = in_tag;
        end else begin : g_src_reg
            assign src_v[j]   = v_q[j-1];
            assign src_b[j]   = b_q[j-1];
            assign src_op[j]  = op_q[j-1];
            assign src_s[j]   = s_q[j-1];
            assign src_c[j]   = c_q[j-1];
            assign src_tag[j] = tag_q[j-1];
        end
        assign b_d[j] = apply_levels(src_b[j], src_op[j], src_s[j], LO, HI);
    end

    // The load condition ripples from the back of the pipe to the front.
    // An empty stage always loads. This collapses bubbles.
    always_comb begin : p_load
        logic ld;
        ld         = ~v_q[LAST] | out_ready;
        load       = '0;
        load[LAST] = ld;
        for (int j = LAST - 1; j >= 0; j--) begin
            ld      = ~v_q[j] | ld;
            load[j] = ld;
        end
    end

    // Pipeline registers. The payload loads only with a real op, so outputs hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < STAGES; j++) begin
                v_q[j]   <= 1'b0;
                b_q[j]   <= '0;
                op_q[j]  <= '0;
                s_q[j]   <= '0;
                c_q[j]   <= 1'b0;
                tag_q[j] <= '0;
            end
            z_q <= 1'b0;
        end else begin
            for (int j = 0; j < STAGES; j++) begin
                if (load[j]) begin
                    v_q[j] <= src_v[j];
                    if (src_v[j]) begin
                        b_q[j]   <= b_d[j];
                        op_q[j]  <= src_op[j];
                        s_q[j]   <= src_s[j];
                        c_q[j]   <= src_c[j];
                        tag_q[j] <= src_tag[j];
                    end
                end
            end
            if (load[LAST] && src_v[LAST]) begin
                z_q <= (b_d[LAST] == '0);
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = v_q[LAST];
    assign out_b     = b_q[LAST];
    assign out_c     = c_q[LAST] & (s_q[LAST] != '0);
    assign out_z     = z_q;
    assign out_bad   = (op_q[LAST] > OP_ROL);
    assign out_tag   = tag_q[LAST];

endmodule
